// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter for a "101" Moore detector: shifts a loaded pattern
// out MSB-first with optional repeats, and predicts the detector output and hit count.
module seq_pattern_tx #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LEN_W = 5,
   parameter int unsigned REP_W = 8,
   parameter int unsigned HIT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] pat_data,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [REP_W-1:0] rep_cnt,
   input  logic             abort,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic             exp_y,
   output logic [HIT_W-1:0] hit_cnt
);

   localparam logic [1:0]       S_IDLE  = 2'd0;
   localparam logic [1:0]       S_SHIFT = 2'd1;
   localparam logic [1:0]       S_DONE  = 2'd2;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;
   logic [REP_W-1:0] r_pass;
   logic             r_x_out;
   logic             r_x_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_start_ready;
   logic [1:0]       r_hist;
   logic             r_exp_y;
   logic [HIT_W-1:0] r_hit_cnt;

   logic [1:0]       w_state_n;
   logic [WIDTH-1:0] w_shreg_n;
   logic [LEN_W-1:0] w_len_n;
   logic [LEN_W-1:0] w_idx_n;
   logic [REP_W-1:0] w_pass_n;
   logic             w_x_out_n;
   logic             w_x_valid_n;
   logic [HIT_W-1:0] w_hit_cnt_n;
   logic [LEN_W-1:0] w_len_in;
   logic             w_accept;
   logic             w_hit;
   logic             w_pat_bit;
   logic             w_next_bit;
   logic             w_wrap_bit;

   // Next-state, datapath and detector-model combinational logic
   always_comb begin
      w_state_n   = r_state;
      w_shreg_n   = r_shreg;
      w_len_n     = r_len;
      w_idx_n     = r_idx;
      w_pass_n    = r_pass;
      w_x_out_n   = 1'b0;
      w_x_valid_n = 1'b0;
      w_hit_cnt_n = r_hit_cnt;

      // Out-of-range lengths fall back to the full pattern width
      w_len_in   = (pat_len == '0 || pat_len > LEN_MAX) ? LEN_MAX : pat_len;
      w_accept   = start_valid & r_start_ready;
      w_pat_bit  = |(pat_data & (WIDTH'(1) << (w_len_in - LEN_W'(1))));
      w_next_bit = |(r_shreg & (WIDTH'(1) << (r_idx - LEN_W'(1))));
      w_wrap_bit = |(r_shreg & (WIDTH'(1) << (r_len - LEN_W'(1))));
      w_hit      = r_x_out & (r_hist == 2'b10);

      if (r_state == S_SHIFT && w_hit && r_hit_cnt != '1) begin
         w_hit_cnt_n = r_hit_cnt + HIT_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_n   = S_SHIFT;
               w_shreg_n   = pat_data;
               w_len_n     = w_len_in;
               w_idx_n     = w_len_in - LEN_W'(1);
               w_pass_n    = rep_cnt;
               w_x_out_n   = w_pat_bit;
               w_x_valid_n = 1'b1;
               w_hit_cnt_n = '0;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_state_n = S_IDLE;
            end else if (r_idx != '0) begin
               w_idx_n     = r_idx - LEN_W'(1);
               w_x_out_n   = w_next_bit;
               w_x_valid_n = 1'b1;
            end else if (r_pass != '0) begin
               // Seamless reload for the next pass, no gap cycle
               w_idx_n     = r_len - LEN_W'(1);
               w_pass_n    = r_pass - REP_W'(1);
               w_x_out_n   = w_wrap_bit;
               w_x_valid_n = 1'b1;
            end else begin
               w_state_n = S_DONE;
            end
         end
         S_DONE: begin
            w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_shreg       <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_pass        <= '0;
         r_x_out       <= 1'b0;
         r_x_valid     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_start_ready <= 1'b1;
         r_hist        <= 2'b00;
         r_exp_y       <= 1'b0;
         r_hit_cnt     <= '0;
      end else begin
         r_state       <= w_state_n;
         r_shreg       <= w_shreg_n;
         r_len         <= w_len_n;
         r_idx         <= w_idx_n;
         r_pass        <= w_pass_n;
         r_x_out       <= w_x_out_n;
         r_x_valid     <= w_x_valid_n;
         r_busy        <= (w_state_n != S_IDLE);
         r_done        <= (w_state_n == S_DONE);
         r_start_ready <= (w_state_n == S_IDLE);
         r_hist        <= {r_hist[0], r_x_out};
         r_exp_y       <= w_hit;
         r_hit_cnt     <= w_hit_cnt_n;
      end
   end

   assign start_ready = r_start_ready;
   assign x_out       = r_x_out;
   assign x_valid     = r_x_valid;
   assign busy        = r_busy;
   assign done        = r_done;
   assign exp_y       = r_exp_y;
   assign hit_cnt     = r_hit_cnt;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected bit streams,
// a negedge monitor checks stream, handshake, detector prediction and hit counts.
module tb_seq_pattern_tx;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned LEN_W = 5;
   localparam int unsigned REP_W = 8;
   localparam int unsigned HIT_W = 16;
   localparam int unsigned SAT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start_valid = 1'b0;
   logic [WIDTH-1:0] pat_data = '0;
   logic [LEN_W-1:0] pat_len = '0;
   logic [REP_W-1:0] rep_cnt = '0;
   logic             abort = 1'b0;

   logic             start_ready, x_out, x_valid, busy, done, exp_y;
   logic [HIT_W-1:0] hit_cnt;
   logic             start_ready_s, x_out_s, x_valid_s, busy_s, done_s, exp_y_s;
   logic [SAT_W-1:0] hit_cnt_s;

   int n_checks = 0;
   int n_err    = 0;

   // Expected stream and per-transfer records (bit count, aborted flag)
   logic bit_q[$];
   int   rec_n[$];
   bit   rec_ab[$];

   seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .HIT_W(HIT_W)) u_dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .pat_data(pat_data), .pat_len(pat_len), .rep_cnt(rep_cnt), .abort(abort),
      .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done),
      .exp_y(exp_y), .hit_cnt(hit_cnt)
   );

   seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .HIT_W(SAT_W)) u_sat (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_s),
      .pat_data(pat_data), .pat_len(pat_len), .rep_cnt(rep_cnt), .abort(abort),
      .x_out(x_out_s), .x_valid(x_valid_s), .busy(busy_s), .done(done_s),
      .exp_y(exp_y_s), .hit_cnt(hit_cnt_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input int w);
      int m;
      m = (1 << w) - 1;
      return (c > m) ? m : c;
   endfunction

   // Monitor: reference "101" detector over the expected stream
   bit       active = 1'b0;
   bit       cur_ab = 1'b0;
   int       remaining = 0;
   int       cnt = 0;
   logic [2:0] win = 3'b000;
   logic     prev_hit = 1'b0;

   always @(negedge clk) begin
      logic eb;
      logic hit;
      if (!rst) begin
         active = 1'b0; remaining = 0; cnt = 0; win = 3'b000; prev_hit = 1'b0;
      end else begin
         chk("exp_y", {31'd0, exp_y}, {31'd0, prev_hit});
         chk("exp_y_sat", {31'd0, exp_y_s}, {31'd0, prev_hit});
         chk("x_valid_sat", {31'd0, x_valid_s}, {31'd0, x_valid});
         eb = 1'b0;
         if (x_valid) begin
            if (!active) begin
               if (rec_n.size() == 0) begin
                  chk("unexpected_valid", 32'd1, 32'd0);
               end else begin
                  remaining = rec_n.pop_front();
                  cur_ab    = rec_ab.pop_front();
                  active    = 1'b1;
                  cnt       = 0;
                  chk("hit_cnt_clear", 32'(hit_cnt), 32'd0);
                  chk("hit_cnt_clear_sat", 32'(hit_cnt_s), 32'd0);
               end
            end
            if (active) begin
               if (remaining == 0 || bit_q.size() == 0) begin
                  chk("extra_bit", 32'd1, 32'd0);
               end else begin
                  eb = bit_q.pop_front();
                  remaining--;
                  chk("x_out", {31'd0, x_out}, {31'd0, eb});
                  chk("x_out_sat", {31'd0, x_out_s}, {31'd0, eb});
               end
            end
            chk("status_shift", {26'd0, busy, busy_s, start_ready, start_ready_s, done, done_s},
                32'b110000);
         end else begin
            chk("x_out_idle", {30'd0, x_out, x_out_s}, 32'd0);
            if (active) begin
               active = 1'b0;
               chk("bits_missing", remaining, 0);
               while (remaining > 0 && bit_q.size() > 0) begin
                  void'(bit_q.pop_front());
                  remaining--;
               end
               chk(cur_ab ? "status_abort" : "status_done",
                   {26'd0, busy, busy_s, start_ready, start_ready_s, done, done_s},
                   cur_ab ? 32'b001100 : 32'b110011);
               chk("hit_cnt_end", 32'(hit_cnt), sat(cnt, HIT_W));
               chk("hit_cnt_end_sat", 32'(hit_cnt_s), sat(cnt, SAT_W));
            end else begin
               chk("status_idle", {26'd0, busy, busy_s, start_ready, start_ready_s, done, done_s},
                   32'b001100);
            end
         end
         win = {win[1:0], eb};
         hit = (win == 3'b101);
         if (x_valid && active && hit) cnt++;
         prev_hit = hit;
      end
   end

   task automatic wait_ready();
      int to;
      to = 0;
      while (!start_ready && to < 1000) begin
         @(posedge clk); #1;
         to++;
      end
      if (!start_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   // Issue one transfer; ak>0 aborts during the ak-th bit. Returns aligned at posedge+1.
   task automatic send(input logic [WIDTH-1:0] d, input int l, input int r, input int ak);
      int n, tot, nb;
      n   = (l == 0) ? WIDTH : l;
      tot = n * (r + 1);
      nb  = (ak > 0 && ak <= tot) ? ak : tot;
      wait_ready();
      pat_data = d; pat_len = LEN_W'(l); rep_cnt = REP_W'(r); start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      for (int i = 0; i < nb; i++) bit_q.push_back(d[n - 1 - (i % n)]);
      rec_n.push_back(nb);
      rec_ab.push_back(nb != tot || ak > 0);
      if (ak > 0) begin
         repeat (ak - 1) begin @(posedge clk); #1; end
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ey[1:7];
      logic dn[1:7];
      logic sr[1:7];
      logic [HIT_W-1:0] hc6;
      int to, l, r, n, tot, ak;
      logic [WIDTH-1:0] d;

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("reset_ready", {31'd0, start_ready}, 32'd1);

      // Reset in the middle of a transfer
      send(16'hBEEF, 16, 3, 0);
      repeat (5) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      bit_q.delete(); rec_n.delete(); rec_ab.delete();
      #1;
      chk("rst_async", {24'd0, x_valid, x_out, busy, done, exp_y, start_ready, |hit_cnt, |hit_cnt_s},
          32'b00000100);
      @(posedge clk); #1;
      rst = 1'b1;
      chk("rst_release", {24'd0, x_valid, x_out, busy, done, exp_y, start_ready, |hit_cnt, |hit_cnt_s},
          32'b00000100);

      // 10101 single pass: cycle-accurate exp_y / done / ready
      send(16'h0015, 5, 0, 0);
      hc6 = '0;
      for (int c = 1; c <= 7; c++) begin
         ey[c] = exp_y; dn[c] = done; sr[c] = start_ready;
         if (c == 6) hc6 = hit_cnt;
         @(posedge clk); #1;
      end
      chk("t2_exp_y_c4", {31'd0, ey[4]}, 32'd1);
      chk("t2_exp_y_c5", {31'd0, ey[5]}, 32'd0);
      chk("t2_exp_y_c6", {31'd0, ey[6]}, 32'd1);
      chk("t2_done_c5", {31'd0, dn[5]}, 32'd0);
      chk("t2_done_c6", {31'd0, dn[6]}, 32'd1);
      chk("t2_ready_c6", {31'd0, sr[6]}, 32'd0);
      chk("t2_ready_c7", {31'd0, sr[7]}, 32'd1);
      chk("t2_hit_cnt", 32'(hc6), 32'd2);

      // 101 repeated three times
      send(16'h0005, 3, 2, 0);

      // Full-width ones, start_valid held, back-to-back accept
      wait_ready();
      pat_data = 16'hFFFF; pat_len = '0; rep_cnt = '0; start_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) bit_q.push_back(1'b1);
      rec_n.push_back(16); rec_ab.push_back(1'b0);
      pat_data = 16'h0005; pat_len = LEN_W'(3);
      to = 0;
      while (!done && to < 40) begin @(posedge clk); #1; to++; end
      chk("b2b_done_seen", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      chk("b2b_ready_first_idle", {31'd0, start_ready}, 32'd1);
      bit_q.push_back(1'b1); bit_q.push_back(1'b0); bit_q.push_back(1'b1);
      rec_n.push_back(3); rec_ab.push_back(1'b0);
      @(posedge clk); #1;
      chk("b2b_restart", {31'd0, x_valid}, 32'd1);
      start_valid = 1'b0;

      // Abort during the 4th bit of a 16-bit pattern
      send(16'hA000, 16, 0, 4);
      chk("abort_idle", {29'd0, x_valid, start_ready, done}, 32'b010);
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_hit_hold", 32'(hit_cnt), 32'd1);
      chk("abort_no_done", {31'd0, done}, 32'd0);

      // Saturation on the narrow counter
      send(16'h0002, 2, 3, 0);
      send(16'hAAAA, 16, 0, 0);
      send(16'h0002, 2, 255, 0);

      // Randomized transfers with occasional aborts and gaps
      for (int t = 0; t < 40; t++) begin
         l   = int'($urandom_range(0, 16));
         d   = WIDTH'($urandom);
         r   = int'($urandom_range(0, 3));
         n   = (l == 0) ? 16 : l;
         tot = n * (r + 1);
         ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, tot)) : 0;
         send(d, l, r, ak);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      to = 0;
      while ((rec_n.size() != 0 || active || !start_ready) && to < 2000) begin
         @(posedge clk); #1;
         to++;
      end
      chk("drain", {30'd0, rec_n.size() != 0, active}, 32'd0);
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
